sim_mem_arb: RTL and testbench

Multi-port, latency-configurable simulation memory model with a per-port request/acknowledge handshake and big-endian byte-lane write enables. It sits in the testbench in place of a single-port, unclocked-read memory array. Several RTL requesters (e.g. CPU-side and I/O-side memory buses) share one array through a round-robin arbiter, with programmable access latency to mimic real memory timing.

---
 rtl/sim_mem_arb_if.sv | 28 ++
 rtl/sim_mem_arb.sv | 135 +++++++++++++
 tb/tb_sim_mem_arb.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sim_mem_arb_if.sv
// Request/acknowledge bus between the requesters and the shared simulation memory.
// Every per-port signal is packed with the port index outermost; data words use bit 0 as MSB.
interface sim_mem_arb_if #(
  parameter int NPORTS = 2,
  parameter int NBYTES = 4,
  parameter int WIDTH  = 36,
  parameter int AW     = 12
);
  logic [NPORTS-1:0]              req;
  logic [NPORTS-1:0][NBYTES-1:0]  we;
  logic [NPORTS-1:0][AW-1:0]      addr;
  logic [NPORTS-1:0][0:WIDTH-1]   din;
  logic [NPORTS-1:0]              ack;
  logic [NPORTS-1:0][0:WIDTH-1]   dout;
  logic                           busy;
  logic [NPORTS-1:0][31:0]        rd_count;
  logic [NPORTS-1:0][31:0]        wr_count;

  modport master (
    output req, we, addr, din,
    input  ack, dout, busy, rd_count, wr_count
  );

  modport slave (
    input  req, we, addr, din,
    output ack, dout, busy, rd_count, wr_count
  );
endinterface

// File: rtl/sim_mem_arb.sv
// Multi-port simulation memory: round-robin arbiter, programmable latency, big-endian byte lanes.
// Optional per-port read/write counters are built when SIM_MEM_STATS_EN is defined.
module sim_mem_arb #(
  parameter int SIZE    = 4096,
  parameter int WIDTH   = 36,
  parameter int NBYTES  = 4,
  parameter int NPORTS  = 2,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  sim_mem_arb_if.slave bus
);
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int BW = WIDTH / NBYTES;
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     gnt;
  logic [PW-1:0]     pick;
  logic              found;
  int unsigned       idx;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     cap_addr;
  logic [NBYTES-1:0] cap_we;
  logic [0:WIDTH-1]  cap_din;
  logic              do_grant;
  logic              do_op;
  logic              is_write;
  logic              in_range;

  logic [0:WIDTH-1]  mem [SIZE];

  assign is_write = |cap_we;
  assign in_range = 32'(cap_addr) < 32'(SIZE);
  assign bus.busy = (state != IDLE);

  // Round-robin search starting at ptr, wrapping past the last port.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= 32'(NPORTS)) idx = idx - 32'(NPORTS);
      if (!found && bus.req[PW'(idx)]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // LATENCY=1 still spends one BUSY cycle with a zero count, so the ack edge
  // stays at grant+LATENCY for every setting.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_op     = 1'b0;
    unique case (state)
      IDLE: if (found) begin
        do_grant  = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (cnt == '0) begin
        do_op     = 1'b1;
        state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      gnt      <= '0;
      cnt      <= '0;
      cap_addr <= '0;
      cap_we   <= '0;
      cap_din  <= '0;
      bus.ack  <= '0;
      bus.dout <= '0;
    end else begin
      bus.ack <= '0;
      if (do_grant) begin
        gnt      <= pick;
        ptr      <= (pick == PW'(NPORTS - 1)) ? '0 : pick + 1'b1;
        cnt      <= CW'(LATENCY - 1);
        cap_addr <= bus.addr[pick];
        cap_we   <= bus.we[pick];
        cap_din  <= bus.din[pick];
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (do_op) begin
        bus.ack[gnt] <= 1'b1;
        if (!is_write) bus.dout[gnt] <= in_range ? mem[cap_addr] : '0;
      end
    end
  end

  // Array has no reset so an aborted access or a reset never disturbs contents.
  always_ff @(posedge clk) begin
    if (do_op && is_write && in_range) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (cap_we[i]) mem[cap_addr][i*BW +: BW] <= cap_din[i*BW +: BW];
      end
    end
  end

`ifdef SIM_MEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_count <= '0;
      bus.wr_count <= '0;
    end else if (do_op) begin
      if (is_write) bus.wr_count[gnt] <= bus.wr_count[gnt] + 32'd1;
      else          bus.rd_count[gnt] <= bus.rd_count[gnt] + 32'd1;
    end
  end
`else
  assign bus.rd_count = '0;
  assign bus.wr_count = '0;
`endif

endmodule

// File: tb/tb_sim_mem_arb.sv
// Bench for sim_mem_arb: directed scenarios plus random multi-port traffic against a transaction-level model.
module tb_sim_mem_arb;
  localparam int SIZE = 3000;
  localparam int W    = 36;
  localparam int NB   = 4;
  localparam int NP   = 3;
  localparam int LAT  = 2;
  localparam int AW   = 12;
  localparam int BW   = W / NB;
`ifdef SIM_MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sim_mem_arb_if #(.NPORTS(NP), .NBYTES(NB), .WIDTH(W), .AW(AW)) bus ();

  sim_mem_arb #(.SIZE(SIZE), .WIDTH(W), .NBYTES(NB), .NPORTS(NP), .LATENCY(LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: timing rules expressed as edge numbers.
  logic [35:0]  mm [int];
  logic [35:0]  m_dout [NP];
  int unsigned  m_rd [NP];
  int unsigned  m_wr [NP];
  bit           pend;
  int           pend_port;
  int unsigned  pend_ack;
  int unsigned  next_grant;
  int           rr;
  logic [3:0]   p_we;
  int           p_addr;
  logic [35:0]  p_din;
  logic [NP-1:0] exp_ack;
  int unsigned  edge_n = 0;

  function automatic logic [35:0] merge(input logic [35:0] old, input logic [35:0] nw,
                                        input logic [3:0] w);
    logic [35:0] mask;
    mask = '0;
    for (int i = 0; i < NB; i++)
      if (w[i]) mask = mask | ((((36'd1) << BW) - 36'd1) << (W - (i + 1) * BW));
    return (old & ~mask) | (nw & mask);
  endfunction

  task automatic cycle();
    @(negedge clk);
    edge_n++;
    exp_ack = '0;
    if (!rst_n) begin
      pend = 0;
      rr = 0;
      next_grant = edge_n + 1;
      for (int p = 0; p < NP; p++) begin
        m_dout[p] = '0; m_rd[p] = 0; m_wr[p] = 0;
      end
    end else begin
      if (pend && edge_n > pend_ack) pend = 0;
      if (pend && edge_n == pend_ack) begin
        exp_ack[pend_port] = 1'b1;
        if (p_we == 4'b0) begin
          m_dout[pend_port] = (p_addr < SIZE && mm.exists(p_addr)) ? mm[p_addr] : 36'd0;
          m_rd[pend_port]++;
        end else begin
          if (p_addr < SIZE) mm[p_addr] = merge(mm.exists(p_addr) ? mm[p_addr] : 36'd0, p_din, p_we);
          m_wr[pend_port]++;
        end
      end
      if (!pend && edge_n >= next_grant && bus.req != '0) begin
        for (int i = 0; i < NP; i++) begin
          int c;
          c = (rr + i) % NP;
          if (!pend && bus.req[c]) begin
            pend = 1; pend_port = c; rr = (c + 1) % NP;
            pend_ack = edge_n + LAT; next_grant = edge_n + LAT + 2;
            p_we = bus.we[c]; p_addr = int'(bus.addr[c]); p_din = bus.din[c];
          end
        end
      end
    end
    check("ack", bus.ack, exp_ack);
    check("busy", bus.busy, pend);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("dout%0d", p), bus.dout[p], m_dout[p]);
      check($sformatf("rdcnt%0d", p), bus.rd_count[p], STATS ? m_rd[p] : 0);
      check($sformatf("wrcnt%0d", p), bus.wr_count[p], STATS ? m_wr[p] : 0);
    end
  endtask

  task automatic set_port(input int p, input logic [3:0] w, input int unsigned a, input logic [35:0] d);
    bus.req[p]  = 1'b1;
    bus.we[p]   = w;
    bus.addr[p] = AW'(a);
    bus.din[p]  = d;
  endtask

  task automatic rand_fields(input int p);
    bus.we[p]   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
    bus.addr[p] = ($urandom_range(0, 7) == 0) ? AW'(SIZE + $urandom_range(0, 3))
                                              : AW'($urandom_range(0, 15));
    bus.din[p]  = 36'({$urandom, $urandom});
  endtask

  task automatic wait_ack(input int p, output int n);
    n = 999;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (bus.ack[p] === 1'b1) begin
        n = i;
        break;
      end
    end
    bus.req[p] = 1'b0;
  endtask

  task automatic access(input string tag, input int p, input logic [3:0] w,
                        input int unsigned a, input logic [35:0] d);
    int n;
    cycle();
    set_port(p, w, a, d);
    wait_ack(p, n);
    check({tag, "_lat"}, n, LAT + 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.req = NP'($urandom);
      for (int p = 0; p < NP; p++) rand_fields(p);
      cycle();
    end
    bus.req = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int nacks;
    logic [NP-1:0] ack_v [3];
    int ack_t [3];

    rst_n    = 1'b0;
    bus.req  = '0;
    bus.we   = '0;
    bus.addr = '0;
    bus.din  = '0;

    // Reset, then a request presented on release is granted at once.
    do_reset();
    set_port(0, 4'b0, 0, 36'd0);
    wait_ack(0, n);
    check("rst_first_lat", n, LAT + 1);

    // Full-word write and readback.
    access("wr5", 0, 4'b1111, 5, 36'o123456701234);
    access("rd5", 0, 4'b0000, 5, 36'd0);
    check("rd5_val", bus.dout[0], 36'o123456701234);

    // Single byte lane 2 (bits 18..26).
    access("lane_wr", 0, 4'b0100, 5, '1);
    access("lane_rd", 0, 4'b0000, 5, 36'd0);
    check("lane_val", bus.dout[0], 36'o123456777234);

    // Contention: ports 0 and 1 hold req through several services.
    do_reset();
    set_port(0, 4'b0, 5, 36'd0);
    set_port(1, 4'b0, 1, 36'd0);
    nacks = 0;
    for (int i = 1; i <= 40 && nacks < 3; i++) begin
      cycle();
      if (bus.ack != '0) begin
        ack_v[nacks] = bus.ack;
        ack_t[nacks] = i;
        nacks++;
      end
    end
    bus.req = '0;
    check("cont_nacks", nacks, 3);
    if (nacks == 3) begin
      check("cont_t0", ack_t[0], LAT + 1);
      check("cont_p0", ack_v[0], 3'b001);
      check("cont_t1", ack_t[1], 2 * LAT + 3);
      check("cont_p1", ack_v[1], 3'b010);
      check("cont_t2", ack_t[2], 3 * LAT + 5);
      check("cont_p2", ack_v[2], 3'b001);
    end

    // Reset during BUSY of a write aborts it.
    access("pre7", 1, 4'b1111, 7, 36'o707070707070);
    cycle();
    set_port(0, 4'b1111, 7, 36'o111111111111);
    cycle();
    check("abort_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    bus.req = '0;
    cycle();
    check("abort_noack", bus.ack, '0);
    cycle();
    rst_n = 1'b1;
    access("rd7", 0, 4'b0000, 7, 36'd0);
    check("rd7_val", bus.dout[0], 36'o707070707070);

    // Out-of-range accesses.
    access("oor_wr", 1, 4'b1111, SIZE, '1);
    access("oor_rd", 1, 4'b0000, SIZE, 36'd0);
    check("oor_val", bus.dout[1], 36'd0);
    access("oor_rd0", 0, 4'b0000, SIZE + 1, 36'd0);
    check("oor_val0", bus.dout[0], 36'd0);

    // Per-port statistics.
    do_reset();
    for (int i = 0; i < 3; i++) access("st_wr", 1, 4'b1111, 20 + i, 36'(i + 1));
    for (int i = 0; i < 2; i++) access("st_rd", 1, 4'b0000, 20 + i, 36'd0);
    check("st_wr1", bus.wr_count[1], STATS ? 3 : 0);
    check("st_rd1", bus.rd_count[1], STATS ? 2 : 0);
    check("st_wr0", bus.wr_count[0], 0);
    check("st_rd0", bus.rd_count[0], 0);

    // Random traffic on all ports.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cycle();
      for (int p = 0; p < NP; p++) begin
        if (exp_ack[p]) bus.req[p] = 1'b0;
        else if (pend && pend_port == p) rand_fields(p);
        else if (!bus.req[p] && $urandom_range(0, 3) == 0) begin
          rand_fields(p);
          bus.req[p] = 1'b1;
        end
      end
    end
    bus.req = '0;
    for (int i = 0; i < 2 * LAT + 4; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
